// File: rtl/nand_cpu_pkg.sv
// Shared rename-stage types: map arrays, checkpoint pointers and sizing constants.
// Pure declarations; no timing or flow-control behaviour of its own.
package nand_cpu_pkg;

    localparam int NUM_ARCH_R = 8;
    localparam int NUM_ARCH_S = 2;
    localparam int NUM_D_REG  = 32;
    localparam int NUM_S_REG  = 8;
    localparam int NUM_CKPT   = 4;

    localparam int AR_W = $clog2(NUM_ARCH_R);
    localparam int AS_W = $clog2(NUM_ARCH_S);
    localparam int PR_W = $clog2(NUM_D_REG);
    localparam int PS_W = $clog2(NUM_S_REG);
    localparam int CK_W = $clog2(NUM_CKPT);

    typedef logic [NUM_ARCH_R-1:0][PR_W-1:0] r_map_t;
    typedef logic [NUM_ARCH_S-1:0][PS_W-1:0] s_map_t;

    // The wrap bit tells a full buffer apart from an empty one when idx matches.
    typedef struct packed {
        logic            wrap;
        logic [CK_W-1:0] idx;
    } ckpt_ptr_t;

    function automatic ckpt_ptr_t ckpt_inc(input ckpt_ptr_t p);
        logic [CK_W:0] v;
        v = p;
        v = v + (CK_W+1)'(1);
        return v;
    endfunction

endpackage

// File: rtl/register_alias_table_if.sv
// Decode-side bundle of the register alias table: rename request, lookups, recovery.
// Outputs are combinational from RAT state; stall is the only backpressure.
interface register_alias_table_if;
    import nand_cpu_pkg::*;

    logic            rename_valid;
    logic [AR_W-1:0] arch_ra;
    logic [AR_W-1:0] arch_rb;
    logic [AS_W-1:0] arch_rs_src;
    logic [AR_W-1:0] arch_rw;
    logic [AS_W-1:0] arch_rs_dst;
    logic            use_rw;
    logic            use_rs;
    logic            is_branch;
    logic [PR_W-1:0] new_rw;
    logic [PS_W-1:0] new_rs;
    logic [PR_W-1:0] phys_ra;
    logic [PR_W-1:0] phys_rb;
    logic [PS_W-1:0] phys_rs_src;
    logic [PR_W-1:0] old_rw;
    logic [PS_W-1:0] old_rs;
    logic [CK_W-1:0] ckpt_id;
    logic            stall;
    logic            restore_valid;
    logic [CK_W-1:0] restore_id;
    logic            release_valid;

    modport master (
        output rename_valid, arch_ra, arch_rb, arch_rs_src, arch_rw, arch_rs_dst,
               use_rw, use_rs, is_branch, new_rw, new_rs,
               restore_valid, restore_id, release_valid,
        input  phys_ra, phys_rb, phys_rs_src, old_rw, old_rs, ckpt_id, stall
    );

    modport slave (
        input  rename_valid, arch_ra, arch_rb, arch_rs_src, arch_rw, arch_rs_dst,
               use_rw, use_rs, is_branch, new_rw, new_rs,
               restore_valid, restore_id, release_valid,
        output phys_ra, phys_rb, phys_rs_src, old_rw, old_rs, ckpt_id, stall
    );

endinterface

// File: rtl/rat_checkpoint_buffer.sv
// Circular buffer of map snapshots with head/tail pointers; snapshot read is combinational.
// Writes land at the next edge; caller must not write while full (it stalls instead).
module rat_checkpoint_buffer
    import nand_cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            snap_we,
    input  r_map_t          snap_r_wr,
    input  s_map_t          snap_s_wr,
    input  logic            release_valid,
    input  logic            restore_valid,
    input  logic [CK_W-1:0] restore_id,
    output logic [CK_W-1:0] tail_idx,
    output logic            full,
    output r_map_t          snap_r_rd,
    output s_map_t          snap_s_rd
);

    r_map_t    snap_r_q [DEPTH];
    r_map_t    snap_r_d [DEPTH];
    s_map_t    snap_s_q [DEPTH];
    s_map_t    snap_s_d [DEPTH];
    ckpt_ptr_t head_q, head_d;
    ckpt_ptr_t tail_q, tail_d;
    logic      empty;

    assign empty     = (head_q == tail_q);
    assign full      = (head_q.idx == tail_q.idx) && (head_q.wrap != tail_q.wrap);
    assign tail_idx  = tail_q.idx;
    assign snap_r_rd = snap_r_q[restore_id];
    assign snap_s_rd = snap_s_q[restore_id];

    always_comb begin
        snap_r_d = snap_r_q;
        snap_s_d = snap_s_q;
        if (snap_we) begin
            snap_r_d[tail_q.idx] = snap_r_wr;
            snap_s_d[tail_q.idx] = snap_s_wr;
        end
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (release_valid) begin
            head_d = ckpt_inc(head_q);
        end
        // Restored slot lies in [head, tail); below head.idx means it sits past the wrap.
        if (restore_valid) begin
            tail_d.idx  = restore_id;
            tail_d.wrap = (restore_id >= head_q.idx) ? head_q.wrap : ~head_q.wrap;
        end else if (snap_we) begin
            tail_d = ckpt_inc(tail_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        snap_r_q <= snap_r_d;
        snap_s_q <= snap_s_d;
    end

    a_release_not_empty: assert property (
        @(posedge clk) disable iff (!n_rst) release_valid |-> !empty
    );

    a_release_restore_head: assert property (
        @(posedge clk) disable iff (!n_rst)
        (release_valid && restore_valid) |-> (restore_id != head_q.idx)
    );

endmodule

// File: rtl/register_alias_table.sv
// Architectural-to-physical rename map for R and S files with one-cycle branch recovery.
// Lookups are 0-cycle; updates land next edge; stall when a branch finds checkpoints full.
module register_alias_table #(
    parameter int NUM_ARCH_R = 8,
    parameter int NUM_ARCH_S = 2,
    parameter int NUM_D_REG  = 32,
    parameter int NUM_S_REG  = 8,
    parameter int NUM_CKPT   = 4
) (
    input  logic                   clk,
    input  logic                   n_rst,
    register_alias_table_if.slave  rat_if
);
    import nand_cpu_pkg::*;

    localparam int D_W = $clog2(NUM_D_REG);
    localparam int S_W = $clog2(NUM_S_REG);

    r_map_t          r_map_q, r_map_d, r_map_wr, r_ident, snap_r_rd;
    s_map_t          s_map_q, s_map_d, s_map_wr, s_ident, snap_s_rd;
    logic            accept;
    logic            full;
    logic [CK_W-1:0] tail_idx;

    always_comb begin
        r_ident = '0;
        s_ident = '0;
        for (int i = 0; i < NUM_ARCH_R; i++) r_ident[i] = D_W'(i);
        for (int i = 0; i < NUM_ARCH_S; i++) s_ident[i] = S_W'(i);
    end

    // Stall looks only at registered fullness, so a same-cycle release cannot clear it.
    assign rat_if.stall = rat_if.rename_valid & rat_if.is_branch & full;
    assign accept       = rat_if.rename_valid & ~rat_if.stall & ~rat_if.restore_valid;

    // Sources read the pre-update map: no bypass from this instruction's own destination.
    assign rat_if.phys_ra     = r_map_q[rat_if.arch_ra];
    assign rat_if.phys_rb     = r_map_q[rat_if.arch_rb];
    assign rat_if.phys_rs_src = s_map_q[rat_if.arch_rs_src];
    assign rat_if.old_rw      = r_map_q[rat_if.arch_rw];
    assign rat_if.old_rs      = s_map_q[rat_if.arch_rs_dst];
    assign rat_if.ckpt_id     = tail_idx;

    always_comb begin
        r_map_wr = r_map_q;
        s_map_wr = s_map_q;
        if (rat_if.use_rw) r_map_wr[rat_if.arch_rw]     = rat_if.new_rw;
        if (rat_if.use_rs) s_map_wr[rat_if.arch_rs_dst] = rat_if.new_rs;
    end

    always_comb begin
        r_map_d = r_map_q;
        s_map_d = s_map_q;
        if (rat_if.restore_valid) begin
            r_map_d = snap_r_rd;
            s_map_d = snap_s_rd;
        end else if (accept) begin
            r_map_d = r_map_wr;
            s_map_d = s_map_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_map_q <= r_ident;
            s_map_q <= s_ident;
        end else begin
            r_map_q <= r_map_d;
            s_map_q <= s_map_d;
        end
    end

    // The snapshot holds the map after the branch's own destination write.
    rat_checkpoint_buffer #(
        .DEPTH (NUM_CKPT)
    ) u_ckpt (
        .clk           (clk),
        .n_rst         (n_rst),
        .snap_we       (accept & rat_if.is_branch),
        .snap_r_wr     (r_map_wr),
        .snap_s_wr     (s_map_wr),
        .release_valid (rat_if.release_valid),
        .restore_valid (rat_if.restore_valid),
        .restore_id    (rat_if.restore_id),
        .tail_idx      (tail_idx),
        .full          (full),
        .snap_r_rd     (snap_r_rd),
        .snap_s_rd     (snap_s_rd)
    );

endmodule

// File: tb/tb_register_alias_table.sv
// Scoreboarded bench for the register alias table: rename, hazard, checkpoint, stall, restore, reset.
module tb_register_alias_table;

    logic clk;
    logic n_rst;

    register_alias_table_if rat_if ();

    register_alias_table dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .rat_if (rat_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {S_RA, S_RB, S_RS, S_ORW, S_ORS, S_CK, S_STALL} sel_e;
    typedef struct {
        sel_e        sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Expectations queued during a cycle are compared against live outputs at its negedge.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.sel)
                S_RA:    act = 32'(rat_if.phys_ra);
                S_RB:    act = 32'(rat_if.phys_rb);
                S_RS:    act = 32'(rat_if.phys_rs_src);
                S_ORW:   act = 32'(rat_if.old_rw);
                S_ORS:   act = 32'(rat_if.old_rs);
                S_CK:    act = 32'(rat_if.ckpt_id);
                default: act = 32'(rat_if.stall);
            endcase
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got %0d expected %0d", e.name, act, e.val);
            end
        end
    end

    task automatic expect_val(input sel_e s, input int v, input string n);
        exp_t e;
        e.sel  = s;
        e.val  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic idle();
        rat_if.rename_valid  = 1'b0;
        rat_if.arch_ra       = '0;
        rat_if.arch_rb       = '0;
        rat_if.arch_rs_src   = '0;
        rat_if.arch_rw       = '0;
        rat_if.arch_rs_dst   = '0;
        rat_if.use_rw        = 1'b0;
        rat_if.use_rs        = 1'b0;
        rat_if.is_branch     = 1'b0;
        rat_if.new_rw        = '0;
        rat_if.new_rs        = '0;
        rat_if.restore_valid = 1'b0;
        rat_if.restore_id    = '0;
        rat_if.release_valid = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rename_rw(input int rw, input int nw, input logic br);
        rat_if.rename_valid = 1'b1;
        rat_if.use_rw       = 1'b1;
        rat_if.arch_rw      = 3'(rw);
        rat_if.new_rw       = 5'(nw);
        rat_if.is_branch    = br;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        idle();
        next_cycle();
        rename_rw(3, 9, 1'b1);
        next_cycle();
        n_rst = 1'b1;
        rat_if.arch_ra = 3'd7; rat_if.arch_rb = 3'd4; rat_if.arch_rs_src = 1'b1;
        rat_if.arch_rw = 3'd6; rat_if.arch_rs_dst = 1'b0;
        expect_val(S_RA, 7, "reset phys_ra");
        expect_val(S_RB, 4, "reset phys_rb");
        expect_val(S_RS, 1, "reset phys_rs_src");
        expect_val(S_ORW, 6, "reset old_rw");
        expect_val(S_ORS, 0, "reset old_rs");
        expect_val(S_STALL, 0, "reset stall");
        expect_val(S_CK, 0, "reset ckpt_id");
        next_cycle();
        rat_if.arch_ra = 3'd3;
        expect_val(S_RA, 3, "rename during reset ignored");
    endtask

    task automatic test_rename();
        next_cycle();
        rename_rw(3, 20, 1'b0);
        rat_if.use_rs = 1'b1; rat_if.arch_rs_dst = 1'b1; rat_if.new_rs = 3'd5;
        rat_if.arch_ra = 3'd3;
        expect_val(S_ORW, 3, "rename old_rw");
        expect_val(S_ORS, 1, "rename old_rs");
        expect_val(S_RA, 3, "rename pre-update ra");
        next_cycle();
        rat_if.arch_ra = 3'd3; rat_if.arch_rw = 3'd3;
        rat_if.arch_rs_src = 1'b1; rat_if.arch_rs_dst = 1'b1;
        expect_val(S_RA, 20, "rename visible ra");
        expect_val(S_ORW, 20, "rename visible old_rw");
        expect_val(S_RS, 5, "rename visible rs");
        expect_val(S_ORS, 5, "rename visible old_rs");
    endtask

    task automatic test_same_cycle_hazard();
        next_cycle();
        rename_rw(5, 21, 1'b0);
        rat_if.arch_ra = 3'd5;
        expect_val(S_RA, 5, "hazard no bypass");
        expect_val(S_ORW, 5, "hazard old_rw");
        next_cycle();
        rat_if.arch_ra = 3'd5;
        expect_val(S_RA, 21, "hazard next cycle");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            rename_rw(6, 10 + k, 1'b0);
            expect_val(S_ORW, (k == 0) ? 6 : 9 + k, "back_to_back old_rw");
        end
        next_cycle();
        rat_if.arch_ra = 3'd6; rat_if.arch_rb = 3'd6;
        expect_val(S_RA, 12, "back_to_back ra");
        expect_val(S_RB, 12, "back_to_back rb");
    endtask

    task automatic test_checkpoint_restore();
        next_cycle();
        rename_rw(2, 22, 1'b1);
        expect_val(S_CK, 0, "branch ckpt_id");
        expect_val(S_ORW, 2, "branch old_rw");
        expect_val(S_STALL, 0, "branch stall");
        next_cycle();
        rename_rw(2, 23, 1'b0);
        expect_val(S_ORW, 22, "post-branch old_rw");
        next_cycle();
        rat_if.restore_valid = 1'b1; rat_if.restore_id = 2'd0;
        rat_if.arch_ra = 3'd2;
        expect_val(S_RA, 23, "restore not yet visible");
        next_cycle();
        rat_if.arch_ra = 3'd2; rat_if.arch_rb = 3'd3; rat_if.arch_rs_src = 1'b1;
        expect_val(S_RA, 22, "restored ra");
        expect_val(S_RB, 20, "restored rb");
        expect_val(S_RS, 5, "restored rs");
    endtask

    task automatic test_full_stall();
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            rename_rw(4, 24 + k, 1'b1);
            expect_val(S_CK, k, "fill ckpt_id");
            expect_val(S_ORW, (k == 0) ? 4 : 23 + k, "fill old_rw");
            expect_val(S_STALL, 0, "fill stall");
        end
        next_cycle();
        rename_rw(4, 28, 1'b1);
        expect_val(S_STALL, 1, "full stall");
        expect_val(S_ORW, 27, "full old_rw");
        next_cycle();
        rename_rw(4, 28, 1'b1);
        rat_if.release_valid = 1'b1;
        rat_if.arch_ra = 3'd4;
        expect_val(S_STALL, 1, "stall held during release");
        expect_val(S_RA, 27, "stalled map unchanged");
        next_cycle();
        rename_rw(4, 28, 1'b1);
        expect_val(S_STALL, 0, "stall after release");
        expect_val(S_CK, 0, "wrapped ckpt_id");
        expect_val(S_ORW, 27, "wrapped old_rw");
        next_cycle();
        rat_if.arch_ra = 3'd4;
        expect_val(S_RA, 28, "wrapped branch map");
    endtask

    task automatic test_restore_drops_rename();
        next_cycle();
        rename_rw(1, 30, 1'b0);
        rat_if.restore_valid = 1'b1; rat_if.restore_id = 2'd2;
        expect_val(S_STALL, 0, "restore cycle stall");
        expect_val(S_ORW, 1, "restore cycle old_rw");
        next_cycle();
        rat_if.rename_valid = 1'b1; rat_if.is_branch = 1'b1;
        rat_if.arch_ra = 3'd1; rat_if.arch_rb = 3'd4;
        expect_val(S_RA, 1, "dropped rename");
        expect_val(S_RB, 26, "snapshot 2 map");
        expect_val(S_CK, 2, "tail at restore_id");
        expect_val(S_STALL, 0, "restore frees slots");
        next_cycle();
        rat_if.arch_ra = 3'd1; rat_if.arch_rb = 3'd4;
        expect_val(S_RA, 1, "dropped rename later");
        expect_val(S_RB, 26, "snapshot 2 map later");
    endtask

    task automatic test_reset_during_restore();
        next_cycle();
        n_rst = 1'b0;
        rename_rw(4, 31, 1'b0);
        rat_if.restore_valid = 1'b1; rat_if.restore_id = 2'd1;
        next_cycle();
        n_rst = 1'b1;
        rat_if.rename_valid = 1'b1; rat_if.is_branch = 1'b1;
        rat_if.arch_ra = 3'd4; rat_if.arch_rb = 3'd2; rat_if.arch_rw = 3'd3;
        rat_if.arch_rs_src = 1'b1;
        expect_val(S_RA, 4, "reset-restore ra");
        expect_val(S_RB, 2, "reset-restore rb");
        expect_val(S_ORW, 3, "reset-restore old_rw");
        expect_val(S_RS, 1, "reset-restore rs");
        expect_val(S_STALL, 0, "reset-restore stall");
        expect_val(S_CK, 0, "reset-restore ckpt_id");
        for (int k = 1; k < 4; k++) begin
            next_cycle();
            rat_if.rename_valid = 1'b1; rat_if.is_branch = 1'b1;
            expect_val(S_CK, k, "post-reset ckpt_id");
        end
        next_cycle();
        rat_if.rename_valid = 1'b1; rat_if.is_branch = 1'b1;
        expect_val(S_STALL, 1, "post-reset full stall");
    endtask

    initial begin
        test_reset();
        test_rename();
        test_same_cycle_hazard();
        test_back_to_back();
        test_checkpoint_restore();
        test_full_stall();
        test_restore_drops_rename();
        test_reset_during_restore();
        next_cycle();
        @(negedge clk);
        #1;
        if (checks < 12) begin
            errors++;
            $display("FAIL too few checks: %0d", checks);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        if (errors == 0) begin
            $display("PASS");
        end else begin
            $display("FAIL");
        end
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1);
    end

endmodule
